// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of the single sram controller.
// Each granted request runs one strobe / ready-low / ready-high handshake and returns a one-cycle ack.
module sram_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_read,

    output logic              grant_b,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    // A wait state is abandoned after exactly TIMEOUT cycles spent in it.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              last_grant, last_grant_nxt;
    logic              we_q, we_nxt;

    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_data_write_nxt;
    logic              mem_read_nxt, mem_write_nxt;
    logic              a_ack_nxt, b_ack_nxt;
    logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt;
    logic              grant_b_nxt, timeout_err_nxt;

    logic              pick_b, start, waiting, wait_done, expired, finish, rd_done;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the port that did not win last time gets the grant.
    assign pick_b    = b_req & (~a_req | ~last_grant);
    assign start     = (state == IDLE) & mem_ready & (a_req | b_req);
    assign waiting   = (state == WAIT_LO) | (state == WAIT_HI);
    assign wait_done = ((state == WAIT_LO) & ~mem_ready) | ((state == WAIT_HI) & mem_ready);
    assign expired   = waiting & ~wait_done & (cnt == CNT_LAST);
    assign finish    = ((state == WAIT_HI) & mem_ready) | expired;
    assign rd_done   = (state == WAIT_HI) & mem_ready & ~we_q;

    assign sel_we    = pick_b ? b_we    : a_we;
    assign sel_addr  = pick_b ? b_addr  : a_addr;
    assign sel_wdata = pick_b ? b_wdata : a_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last_grant     <= 1'b1;
            we_q           <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            grant_b        <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            last_grant     <= last_grant_nxt;
            we_q           <= we_nxt;
            mem_address    <= mem_address_nxt;
            mem_data_write <= mem_data_write_nxt;
            mem_read       <= mem_read_nxt;
            mem_write      <= mem_write_nxt;
            a_ack          <= a_ack_nxt;
            b_ack          <= b_ack_nxt;
            a_rdata        <= a_rdata_nxt;
            b_rdata        <= b_rdata_nxt;
            grant_b        <= grant_b_nxt;
            timeout_err    <= timeout_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!mem_ready)   state_nxt = WAIT_HI;
                else if (expired) state_nxt = IDLE;
            end
            WAIT_HI: if (mem_ready || expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Counter restarts from zero whenever a wait state is entered.
        cnt_nxt = '0;
        if (waiting && (state_nxt == state)) cnt_nxt = cnt + 16'd1;
    end

    always_comb begin
        mem_address_nxt    = mem_address;
        mem_data_write_nxt = mem_data_write;
        we_nxt             = we_q;
        grant_b_nxt        = grant_b;
        last_grant_nxt     = last_grant;
        mem_read_nxt       = 1'b0;
        mem_write_nxt      = 1'b0;
        a_ack_nxt          = 1'b0;
        b_ack_nxt          = 1'b0;
        a_rdata_nxt        = a_rdata;
        b_rdata_nxt        = b_rdata;
        timeout_err_nxt    = timeout_err | expired;

        if (start) begin
            mem_address_nxt    = sel_addr;
            mem_data_write_nxt = sel_wdata;
            we_nxt             = sel_we;
            grant_b_nxt        = pick_b;
            last_grant_nxt     = pick_b;
            mem_write_nxt      = sel_we;
            mem_read_nxt       = ~sel_we;
        end

        // A timed-out read still acks but leaves rdata untouched.
        if (finish) begin
            if (grant_b) begin
                b_ack_nxt = 1'b1;
                if (rd_done) b_rdata_nxt = mem_data_read;
            end else begin
                a_ack_nxt = 1'b1;
                if (rd_done) a_rdata_nxt = mem_data_read;
            end
        end
    end

endmodule
